ctrl_axil_slave: RTL and testbench

AXI4-Lite responder that terminates the control bus driven by the PS/master VIP. It exposes a bank of 32-bit read/write control registers to the PL fabric. It accepts write address and write data channels independently, applies byte strobes, and returns OKAY or SLVERR responses. This block is the register-side endpoint of the control path whose sequential write/readback traffic (addresses 0x0, 0x4, 0x8, 0xC) the master side generates.

---
 rtl/ctrl_axil_slave.sv | 208 ++++++++++++++++++++
 tb/tb_ctrl_axil_slave.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_axil_slave.sv
// AXI4-Lite responder exposing C_NUM_REGS 32-bit control registers.
// AW and W are buffered independently; a write commits once both buffers are full.
module ctrl_axil_slave #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5,
   parameter int C_NUM_REGS         = 4
) (
   input  logic                              ACLK,
   input  logic                              ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_NUM_REGS*32-1:0]          reg_out,
   output logic [C_NUM_REGS-1:0]             reg_wr_pulse
);

   localparam int DW    = C_S_AXI_DATA_WIDTH;
   localparam int SW    = C_S_AXI_DATA_WIDTH / 8;
   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
   localparam logic [IDX_W:0] NUM_REGS_C  = (IDX_W + 1)'(C_NUM_REGS);
   localparam logic [1:0]     RESP_OKAY   = 2'b00;
   localparam logic [1:0]     RESP_SLVERR = 2'b10;

   // Merge new bytes into the old word wherever the strobe is set.
   function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                                input logic [DW-1:0] new_v,
                                                input logic [SW-1:0] strb);
      logic [DW-1:0] res;
      res = old_v;
      for (int b = 0; b < SW; b++) begin
         if (strb[b]) begin
            res[8*b +: 8] = new_v[8*b +: 8];
         end else begin
            res[8*b +: 8] = old_v[8*b +: 8];
         end
      end
      return res;
   endfunction

   function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
      return ({1'b0, idx} < NUM_REGS_C);
   endfunction

   logic                  aw_full_q, aw_full_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic                  w_full_q, w_full_d;
   logic [DW-1:0]         w_data_q, w_data_d;
   logic [SW-1:0]         w_strb_q, w_strb_d;
   logic                  bvalid_q, bvalid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic [DW-1:0]         rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [C_NUM_REGS-1:0] pulse_q, pulse_d;
   logic [DW-1:0]         regs_q [C_NUM_REGS];
   logic [DW-1:0]         regs_d [C_NUM_REGS];

   logic                  aw_hs_s, w_hs_s, ar_hs_s, commit_s, wr_ok_s;
   logic [IDX_W-1:0]      ar_idx_s;
   logic                  unused_inputs_s;

   assign S_AXI_AWREADY = ~aw_full_q & ~bvalid_q;
   assign S_AXI_WREADY  = ~w_full_q & ~bvalid_q;
   assign S_AXI_ARREADY = ~rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = bresp_q;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = rresp_q;
   assign reg_wr_pulse  = pulse_q;

   assign aw_hs_s  = S_AXI_AWVALID & S_AXI_AWREADY;
   assign w_hs_s   = S_AXI_WVALID & S_AXI_WREADY;
   assign ar_hs_s  = S_AXI_ARVALID & S_AXI_ARREADY;
   assign commit_s = aw_full_q & w_full_q & ~bvalid_q;
   assign wr_ok_s  = idx_ok(aw_idx_q);
   assign ar_idx_s = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

   // Byte-offset bits and protection attributes carry no meaning here.
   assign unused_inputs_s = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                              S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   for (genvar n = 0; n < C_NUM_REGS; n++) begin : g_reg_out
      assign reg_out[32*n +: 32] = regs_q[n];
   end

   // Write path: buffer fill, commit into the register bank, B channel.
   always_comb begin
      aw_full_d = aw_full_q;
      aw_idx_d  = aw_idx_q;
      w_full_d  = w_full_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      pulse_d   = {C_NUM_REGS{1'b0}};
      regs_d    = regs_q;
      if (commit_s) begin
         aw_full_d = 1'b0;
         w_full_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (aw_hs_s) begin
            aw_full_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
         end else begin
            aw_full_d = aw_full_q;
         end
         if (w_hs_s) begin
            w_full_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
         end else begin
            w_full_d = w_full_q;
         end
         if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
         end else begin
            bvalid_d = bvalid_q;
         end
      end
      for (int n = 0; n < C_NUM_REGS; n++) begin
         if (commit_s && wr_ok_s && (aw_idx_q == IDX_W'(n))) begin
            regs_d[n]  = apply_strb(regs_q[n], w_data_q, w_strb_q);
            pulse_d[n] = 1'b1;
         end else begin
            regs_d[n]  = regs_q[n];
            pulse_d[n] = 1'b0;
         end
      end
   end

   // Read path: capture pre-edge register value on AR handshake, hold until R handshake.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (ar_hs_s) begin
         rvalid_d = 1'b1;
         rdata_d  = {DW{1'b0}};
         for (int n = 0; n < C_NUM_REGS; n++) begin
            if (ar_idx_s == IDX_W'(n)) begin
               rdata_d = regs_q[n];
            end else begin
               rdata_d = rdata_d;
            end
         end
         rresp_d = idx_ok(ar_idx_s) ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && S_AXI_RREADY) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
   end

   // State registers for both channels and the register bank.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         aw_full_q <= 1'b0;
         aw_idx_q  <= {IDX_W{1'b0}};
         w_full_q  <= 1'b0;
         w_data_q  <= {DW{1'b0}};
         w_strb_q  <= {SW{1'b0}};
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         rvalid_q  <= 1'b0;
         rdata_q   <= {DW{1'b0}};
         rresp_q   <= 2'b00;
         pulse_q   <= {C_NUM_REGS{1'b0}};
         for (int n = 0; n < C_NUM_REGS; n++) begin
            regs_q[n] <= {DW{1'b0}};
         end
      end else begin
         aw_full_q <= aw_full_d;
         aw_idx_q  <= aw_idx_d;
         w_full_q  <= w_full_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         pulse_q   <= pulse_d;
         for (int n = 0; n < C_NUM_REGS; n++) begin
            regs_q[n] <= regs_d[n];
         end
      end
   end

endmodule

// File: tb/tb_ctrl_axil_slave.sv
// Scoreboard bench for ctrl_axil_slave: B/R expectations are queued by the
// stimulus and checked by a negedge monitor on each response handshake.
module tb_ctrl_axil_slave;

   localparam int NR = 4;
   localparam logic [1:0] OK  = 2'b00;
   localparam logic [1:0] ERR = 2'b10;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [4:0]    S_AXI_AWADDR, S_AXI_ARADDR;
   logic [2:0]    S_AXI_AWPROT, S_AXI_ARPROT;
   logic          S_AXI_AWVALID, S_AXI_AWREADY;
   logic [31:0]   S_AXI_WDATA;
   logic [3:0]    S_AXI_WSTRB;
   logic          S_AXI_WVALID, S_AXI_WREADY;
   logic [1:0]    S_AXI_BRESP;
   logic          S_AXI_BVALID, S_AXI_BREADY;
   logic          S_AXI_ARVALID, S_AXI_ARREADY;
   logic [31:0]   S_AXI_RDATA;
   logic [1:0]    S_AXI_RRESP;
   logic          S_AXI_RVALID, S_AXI_RREADY;
   logic [127:0]  reg_out;
   logic [NR-1:0] reg_wr_pulse;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  resp;
   } rexp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          pulse_cnt [NR];
   logic [1:0]  bq [$];
   rexp_t       rq [$];
   logic [1:0]  exp_b;
   rexp_t       exp_r;

   always #5 ACLK = ~ACLK;

   ctrl_axil_slave dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .reg_out(reg_out), .reg_wr_pulse(reg_wr_pulse)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   // Response monitor: pops the scoreboard on every B and R handshake.
   always @(negedge ACLK) begin
      if (!ARESET) begin
         if (S_AXI_BVALID && S_AXI_BREADY) begin
            if (bq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL b_unexpected: got B with BRESP %0b, expected no response", S_AXI_BRESP);
            end else begin
               exp_b = bq.pop_front();
               chk("bresp", {126'd0, S_AXI_BRESP}, {126'd0, exp_b});
            end
         end
         if (S_AXI_RVALID && S_AXI_RREADY) begin
            if (rq.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL r_unexpected: got R data 0x%0h, expected no response", S_AXI_RDATA);
            end else begin
               exp_r = rq.pop_front();
               chk("rdata", {96'd0, S_AXI_RDATA}, {96'd0, exp_r.data});
               chk("rresp", {126'd0, S_AXI_RRESP}, {126'd0, exp_r.resp});
            end
         end
         for (int n = 0; n < NR; n++) begin
            if (reg_wr_pulse[n]) pulse_cnt[n]++;
         end
      end
   end

   task automatic wr_handshakes();
      logic aw_done, w_done;
      for (int c = 0; c < 30 && (S_AXI_AWVALID || S_AXI_WVALID); c++) begin
         aw_done = S_AXI_AWVALID && S_AXI_AWREADY;
         w_done  = S_AXI_WVALID && S_AXI_WREADY;
         tick();
         if (aw_done) S_AXI_AWVALID = 1'b0;
         if (w_done)  S_AXI_WVALID  = 1'b0;
      end
      chk("wr_accept_timeout", {126'd0, S_AXI_AWVALID, S_AXI_WVALID}, 128'd0);
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 30 && (bq.size() != 0 || rq.size() != 0); c++) tick();
      chk("resp_timeout", 128'(bq.size() + rq.size()), 128'd0);
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] resp);
      S_AXI_AWADDR  = a;
      S_AXI_WDATA   = d;
      S_AXI_WSTRB   = s;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      bq.push_back(resp);
      wr_handshakes();
      wait_idle();
   endtask

   task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] resp);
      logic done;
      done = 1'b0;
      S_AXI_ARADDR  = a;
      S_AXI_ARVALID = 1'b1;
      rq.push_back('{data: d, resp: resp});
      for (int c = 0; c < 30 && !done; c++) begin
         done = S_AXI_ARREADY;
         tick();
      end
      chk("ar_accept_timeout", {127'd0, done}, 128'd1);
      S_AXI_ARVALID = 1'b0;
      wait_idle();
   endtask

   task automatic chk_pulses(input int p0, input int p1, input int p2, input int p3);
      chk("pulse_cnt0", 128'(pulse_cnt[0]), 128'(p0));
      chk("pulse_cnt1", 128'(pulse_cnt[1]), 128'(p1));
      chk("pulse_cnt2", 128'(pulse_cnt[2]), 128'(p2));
      chk("pulse_cnt3", 128'(pulse_cnt[3]), 128'(p3));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_awready", {127'd0, S_AXI_AWREADY}, 128'd1);
      chk("rst_wready",  {127'd0, S_AXI_WREADY},  128'd1);
      chk("rst_arready", {127'd0, S_AXI_ARREADY}, 128'd1);
      chk("rst_bvalid",  {127'd0, S_AXI_BVALID},  128'd0);
      chk("rst_rvalid",  {127'd0, S_AXI_RVALID},  128'd0);
      chk("rst_resp",    {124'd0, S_AXI_BRESP, S_AXI_RRESP}, 128'd0);
      chk("rst_rdata",   {96'd0, S_AXI_RDATA},   128'd0);
      chk("rst_reg_out", reg_out, 128'd0);
      chk("rst_pulse",   {124'd0, reg_wr_pulse}, 128'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int n = 0; n < NR; n++) pulse_cnt[n] = 0;
      ARESET = 1'b1;
      S_AXI_AWADDR = 5'd0; S_AXI_AWPROT = 3'd0; S_AXI_AWVALID = 1'b0;
      S_AXI_WDATA = 32'd0; S_AXI_WSTRB = 4'd0; S_AXI_WVALID = 1'b0;
      S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
      S_AXI_ARADDR = 5'd0; S_AXI_ARPROT = 3'd0; S_AXI_ARVALID = 1'b0;
      tick();
      tick();
      chk_reset_outputs();
      ARESET = 1'b0;
      tick();

      // Sequential write / readback of all four registers.
      axi_write(5'h00, 32'h1, 4'hF, OK);
      axi_write(5'h04, 32'h2, 4'hF, OK);
      axi_write(5'h08, 32'h3, 4'hF, OK);
      axi_write(5'h0C, 32'h4, 4'hF, OK);
      axi_read(5'h00, 32'h1, OK);
      axi_read(5'h04, 32'h2, OK);
      axi_read(5'h08, 32'h3, OK);
      axi_read(5'h0C, 32'h4, OK);
      chk("t1_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);
      chk_pulses(1, 1, 1, 1);

      // AW first, W three cycles later.
      S_AXI_AWADDR  = 5'h04;
      S_AXI_AWVALID = 1'b1;
      bq.push_back(OK);
      chk("t2_awready_c0", {127'd0, S_AXI_AWREADY}, 128'd1);
      tick();
      S_AXI_AWVALID = 1'b0;
      chk("t2_awready_full", {127'd0, S_AXI_AWREADY}, 128'd0);
      tick();
      tick();
      S_AXI_WDATA  = 32'hDEADBEEF;
      S_AXI_WSTRB  = 4'hF;
      S_AXI_WVALID = 1'b1;
      chk("t2_bvalid_pre_w", {127'd0, S_AXI_BVALID}, 128'd0);
      tick();
      S_AXI_WVALID = 1'b0;
      chk("t2_bvalid_w_edge", {127'd0, S_AXI_BVALID}, 128'd0);
      chk("t2_wready_full", {127'd0, S_AXI_WREADY}, 128'd0);
      tick();
      chk("t2_bvalid_commit", {127'd0, S_AXI_BVALID}, 128'd1);
      chk("t2_reg1", {96'd0, reg_out[63:32]}, 128'hDEADBEEF);
      wait_idle();
      chk_pulses(1, 2, 1, 1);

      // Byte-strobed partial write.
      axi_write(5'h08, 32'h11223344, 4'hF, OK);
      axi_write(5'h08, 32'hAABBCCDD, 4'b0010, OK);
      chk("t3_reg2", {96'd0, reg_out[95:64]}, 128'h1122CC44);
      axi_read(5'h0A, 32'h1122CC44, OK);
      chk_pulses(1, 2, 3, 1);

      // Out-of-range indices.
      axi_write(5'h10, 32'h55, 4'hF, ERR);
      chk("t4_reg_out", reg_out, 128'h00000004_1122CC44_DEADBEEF_00000001);
      axi_read(5'h14, 32'h0, ERR);
      axi_read(5'h1F, 32'h0, ERR);
      chk_pulses(1, 2, 3, 1);

      // BREADY held low; read on the commit edge sees the old value.
      S_AXI_BREADY  = 1'b0;
      S_AXI_AWADDR  = 5'h00;
      S_AXI_WDATA   = 32'hA5A5A5A5;
      S_AXI_WSTRB   = 4'hF;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      bq.push_back(OK);
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARADDR  = 5'h00;
      S_AXI_ARVALID = 1'b1;
      rq.push_back('{data: 32'h1, resp: OK});
      tick();
      S_AXI_ARVALID = 1'b0;
      S_AXI_AWADDR  = 5'h0C;
      S_AXI_WDATA   = 32'h77;
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      bq.push_back(OK);
      for (int i = 0; i < 5; i++) begin
         chk("t5_bvalid_hold", {127'd0, S_AXI_BVALID}, 128'd1);
         chk("t5_awready_hold", {127'd0, S_AXI_AWREADY}, 128'd0);
         chk("t5_wready_hold", {127'd0, S_AXI_WREADY}, 128'd0);
         tick();
      end
      chk("t5_reg0", {96'd0, reg_out[31:0]}, 128'hA5A5A5A5);
      chk("t5_reg3_untouched", {96'd0, reg_out[127:96]}, 128'h4);
      S_AXI_BREADY = 1'b1;
      wr_handshakes();
      wait_idle();
      chk("t5_reg_out", reg_out, 128'h00000077_1122CC44_DEADBEEF_A5A5A5A5);
      chk_pulses(2, 2, 3, 2);

      // Reset with a buffered AW and a pending R.
      S_AXI_AWADDR  = 5'h00;
      S_AXI_AWVALID = 1'b1;
      tick();
      S_AXI_AWVALID = 1'b0;
      S_AXI_RREADY  = 1'b0;
      S_AXI_ARADDR  = 5'h04;
      S_AXI_ARVALID = 1'b1;
      tick();
      S_AXI_ARVALID = 1'b0;
      chk("t6_rvalid_pending", {127'd0, S_AXI_RVALID}, 128'd1);
      ARESET = 1'b1;
      #1;
      chk_reset_outputs();
      tick();
      tick();
      ARESET = 1'b0;
      S_AXI_RREADY = 1'b1;
      tick();
      S_AXI_WDATA  = 32'h99;
      S_AXI_WSTRB  = 4'hF;
      S_AXI_WVALID = 1'b1;
      wr_handshakes();
      for (int i = 0; i < 4; i++) begin
         chk("t6_no_b", {127'd0, S_AXI_BVALID}, 128'd0);
         tick();
      end
      chk("t6_w_buffered", {127'd0, S_AXI_WREADY}, 128'd0);
      axi_read(5'h00, 32'h0, OK);
      chk("t6_reg_out", reg_out, 128'd0);
      chk_pulses(2, 2, 3, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
